dds_sweep_ctrl: RTL and testbench

- Frequency-sweep controller that sits directly upstream of the DDS core.
- Generates the signed frequency control word (`freq`) and the enable (`en`) for the DDS, stepping linearly from a start word to a stop word with a programmable dwell per step.
- Supports three modes: single-shot, sawtooth repeat and triangle.
- Replaces floating-point sweep generation with synthesizable integer RTL.

---
 rtl/dds_sweep_pkg.sv | 44 ++++
 rtl/dds_sweep_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared types and step arithmetic for the DDS frequency-sweep controller.
//   mode_e     : sweep mode (single, sawtooth repeat, triangle)
//   state_e    : controller state
//   step_clamp : one step of the sweep, clamped to the current target
package dds_sweep_pkg;

  // Must match the PW parameter of dds_sweep_ctrl.
  localparam int unsigned FCW_W = 32;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_UP = 2'd1,
    RUN_DN = 2'd2
  } state_e;

  // Next sweep value, never past target. Two guard bits are used so that even a
  // full-range unsigned step cannot wrap the intermediate sum.
  function automatic logic signed [FCW_W-1:0] step_clamp(
    input logic signed [FCW_W-1:0] cur,
    input logic        [FCW_W-1:0] step,
    input logic signed [FCW_W-1:0] target,
    input logic                    up
  );
    logic signed [FCW_W+1:0] cur_x;
    logic signed [FCW_W+1:0] step_x;
    logic signed [FCW_W+1:0] tgt_x;
    logic signed [FCW_W+1:0] nxt;
    cur_x  = {{2{cur[FCW_W-1]}}, cur};
    step_x = {2'b00, step};
    tgt_x  = {{2{target[FCW_W-1]}}, target};
    nxt    = up ? (cur_x + step_x) : (cur_x - step_x);
    if (up ? (nxt > tgt_x) : (nxt < tgt_x)) begin
      nxt = tgt_x;
    end
    return nxt[FCW_W-1:0];
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller feeding a DDS core.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, abort     : begin sweep (sampled in IDLE only), stop sweep immediately
//   mode             : 0 single, 1 sawtooth repeat, 2 triangle, 3 single
//   f_start, f_stop  : signed start/stop frequency control words
//   f_step           : unsigned step magnitude (0 behaves as 1)
//   dwell            : each freq value is held dwell+1 cycles
//   freq, en, busy   : FCW to DDS, DDS enable (= busy), sweep in progress
//   done, wrap       : single-sweep completion pulse, sawtooth reload / triangle turn pulse
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int unsigned PW  = FCW_W,
  parameter int unsigned DWW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic signed [PW-1:0] f_start,
  input  logic signed [PW-1:0] f_stop,
  input  logic [PW-1:0]        f_step,
  input  logic [DWW-1:0]       dwell,
  output logic signed [PW-1:0] freq,
  output logic                 en,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap
);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic signed [PW-1:0] freq_q, freq_d;
  logic signed [PW-1:0] start_q, start_d;
  // hi/lo are the larger/smaller endpoint: RUN_UP always heads for hi, RUN_DN for lo.
  logic signed [PW-1:0] hi_q, hi_d;
  logic signed [PW-1:0] lo_q, lo_d;
  logic [PW-1:0]        step_q, step_d;
  logic [DWW-1:0]       dwell_q, dwell_d;
  logic [DWW-1:0]       cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap_q, wrap_d;

  logic                 up;
  logic                 start_up;
  logic signed [PW-1:0] tgt;
  logic signed [PW-1:0] rev_tgt;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    freq_d   = freq_q;
    start_d  = start_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    up       = (state_q == RUN_UP);
    tgt      = up ? hi_q : lo_q;
    rev_tgt  = up ? lo_q : hi_q;
    start_up = (f_stop >= f_start);

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = start_up ? RUN_UP : RUN_DN;
          freq_d  = f_start;
          busy_d  = 1'b1;
          cnt_d   = '0;
          start_d = f_start;
          hi_d    = start_up ? f_stop : f_start;
          lo_d    = start_up ? f_start : f_stop;
          step_d  = (f_step == '0) ? {{(PW-1){1'b0}}, 1'b1} : f_step;
          dwell_d = dwell;
          case (mode)
            2'd1:    mode_d = MODE_SAW;
            2'd2:    mode_d = MODE_TRI;
            default: mode_d = MODE_SINGLE;
          endcase
        end
      end
      RUN_UP, RUN_DN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (freq_q != tgt) begin
            freq_d = step_clamp(freq_q, step_q, tgt, up);
          end else begin
            case (mode_q)
              MODE_SAW: begin
                freq_d = start_q;
                wrap_d = 1'b1;
              end
              MODE_TRI: begin
                // Step straight off the endpoint so it is not shown twice.
                state_d = up ? RUN_DN : RUN_UP;
                freq_d  = step_clamp(freq_q, step_q, rev_tgt, !up);
                wrap_d  = 1'b1;
              end
              default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_SINGLE;
      freq_q  <= '0;
      start_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      freq_q  <= freq_d;
      start_q <= start_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign freq = freq_q;
  assign busy = busy_q;
  assign en   = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl.
module tb_dds_sweep_ctrl;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [1:0]         mode;
  logic signed [31:0] f_start;
  logic signed [31:0] f_stop;
  logic [31:0]        f_step;
  logic [15:0]        dwell;
  logic signed [31:0] freq;
  logic               en;
  logic               busy;
  logic               done;
  logic               wrap;

  int n_vec;
  int n_err;

  logic [31:0] ef[$];
  logic        ew[$];

  dds_sweep_ctrl #(
    .PW (32),
    .DWW(16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .mode   (mode),
    .f_start(f_start),
    .f_stop (f_stop),
    .f_step (f_step),
    .dwell  (dwell),
    .freq   (freq),
    .en     (en),
    .busy   (busy),
    .done   (done),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                          input logic [31:0] st, input logic [15:0] dw);
    mode    = m;
    f_start = fs;
    f_stop  = fe;
    f_step  = st;
    dwell   = dw;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Walk ef/ew: one entry per cycle, first entry is the cycle right after start.
  task automatic check_seq(input string tag);
    for (int i = 0; i < ef.size(); i++) begin
      if (i > 0) tick();
      check({tag, "_freq"}, freq, ef[i]);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_en"}, {31'd0, en}, 32'd1);
      check({tag, "_wrap"}, {31'd0, wrap}, {31'd0, ew[i]});
      check({tag, "_done"}, {31'd0, done}, 32'd0);
    end
  endtask

  task automatic check_done(input string tag, input logic [31:0] last);
    tick();
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"}, freq, last);
    tick();
    check({tag, "_done_lo"}, {31'd0, done}, 32'd0);
    check({tag, "_hold2"}, freq, last);
  endtask

  task automatic single_up(input string tag);
    do_start(2'd0, 32'd100, 32'd130, 32'd10, 16'd1);
    ef = '{32'd100, 32'd100, 32'd110, 32'd110, 32'd120, 32'd120, 32'd130, 32'd130};
    ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_seq(tag);
    check_done(tag, 32'd130);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    mode    = 2'd0;
    f_start = '0;
    f_stop  = '0;
    f_step  = '0;
    dwell   = '0;
    #12;
    check("rst_freq", freq, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    rst_n = 1'b1;
    tick();

    single_up("up");

    do_start(2'd0, 32'd50, -32'sd15, 32'd20, 16'd0);
    ef = '{32'd50, 32'd30, 32'd10, -32'sd10, -32'sd15};
    ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_seq("dn");
    check_done("dn", -32'sd15);

    do_start(2'd3, 32'd0, 32'd25, 32'd10, 16'd0);
    ef = '{32'd0, 32'd10, 32'd20, 32'd25};
    ew = '{1'b0, 1'b0, 1'b0, 1'b0};
    check_seq("clamp");
    check_done("clamp", 32'd25);

    do_start(2'd0, 32'h7FFFFFF0, 32'h7FFFFFFF, 32'h40000000, 16'd0);
    ef = '{32'h7FFFFFF0, 32'h7FFFFFFF};
    ew = '{1'b0, 1'b0};
    check_seq("ovf");
    check_done("ovf", 32'h7FFFFFFF);

    // Sawtooth, then abort while showing 10.
    do_start(2'd1, 32'd0, 32'd20, 32'd10, 16'd0);
    ef = '{32'd0, 32'd10, 32'd20, 32'd0, 32'd10, 32'd20, 32'd0, 32'd10};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    check_seq("saw");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_freq", freq, 32'd10);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_wrap", {31'd0, wrap}, 32'd0);
    tick();
    check("abort_idle", {31'd0, busy}, 32'd0);

    // Triangle, with an ignored restart while running.
    do_start(2'd2, 32'd0, 32'd20, 32'd10, 16'd0);
    ef = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20, 32'd10};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    check_seq("tri");
    do_start(2'd0, 32'd500, 32'd600, 32'd1, 16'd0);
    check("restart_freq", freq, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    tick();
    check("restart_turn", freq, 32'd10);
    check("restart_wrap", {31'd0, wrap}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("tri_abort", {31'd0, busy}, 32'd0);
    check("tri_abort_freq", freq, 32'd10);

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    f_start = 32'd777;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", {31'd0, busy}, 32'd0);
    check("sa_freq", freq, 32'd10);

    // Equal endpoints in sawtooth: hold with periodic wrap.
    do_start(2'd1, 32'd5, 32'd5, 32'd0, 16'd1);
    ef = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
    ew = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    check_seq("eq");
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset mid-sweep.
    do_start(2'd0, 32'd100, 32'd130, 32'd10, 16'd1);
    tick();
    tick();
    check("pre_rst_freq", freq, 32'd110);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_freq", freq, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_wrap", {31'd0, wrap}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    single_up("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
